// File: rtl/mem_ctrl.sv
// Byte-serial RAM sequencer/arbiter shared by instruction fetch and data access.
// MEM has priority over IF; also produces the pipeline stall vector.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_inst,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  input  logic              id_stallreq,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din,
  output logic [5:0]        stall
);

  typedef enum logic [2:0] {S_IDLE, S_IF_RD, S_MEM_RD, S_MEM_WR, S_DONE} state_t;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_base, r_ram_a;
  logic [2:0]        r_len, r_cnt;
  logic [31:0]       r_wdata, r_buf, r_if_inst, r_mem_rdata;
  logic              r_owner_mem, r_ram_wr;
  logic [7:0]        r_ram_dout;

  logic              w_rd, w_last_cap, w_last_wr, w_accept_mem, w_accept_if;
  logic [2:0]        w_mem_len, w_cnt_inc;
  logic [1:0]        w_cap_lane, w_wr_lane;
  logic [ADDR_W-1:0] w_addr_next;
  logic [31:0]       w_buf_next;
  logic [7:0]        w_wr_byte;

  assign w_rd         = (r_state == S_IF_RD) || (r_state == S_MEM_RD);
  assign w_accept_mem = (r_state == S_IDLE) && mem_req;
  assign w_accept_if  = (r_state == S_IDLE) && !mem_req && if_req;
  // r_cnt counts cycles spent in a read state; lane r_cnt-1 arrives on ram_din
  assign w_last_cap   = w_rd && (r_cnt == r_len);
  assign w_last_wr    = (r_state == S_MEM_WR) && (r_cnt == r_len - 3'd1);
  assign w_cnt_inc    = r_cnt + 3'd1;
  assign w_cap_lane   = 2'(r_cnt - 3'd1);
  assign w_wr_lane    = 2'(w_cnt_inc);
  assign w_addr_next  = r_base + {{(ADDR_W-3){1'b0}}, w_cnt_inc};
  assign w_wr_byte    = r_wdata[{w_wr_lane, 3'b000} +: 8];

  always_comb begin
    w_mem_len = 3'd4;
    case (mem_len)
      2'b00:   w_mem_len = 3'd1;
      2'b01:   w_mem_len = 3'd2;
      default: w_mem_len = 3'd4;
    endcase
  end

  always_comb begin
    w_buf_next = r_buf;
    if (w_rd && (r_cnt != 3'd0))
      w_buf_next[{w_cap_lane, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if_done      = 1'b0;
    mem_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req)     w_state_next = mem_we ? S_MEM_WR : S_MEM_RD;
        else if (if_req) w_state_next = S_IF_RD;
      end
      S_IF_RD, S_MEM_RD: if (w_last_cap) w_state_next = S_DONE;
      S_MEM_WR:          if (w_last_wr)  w_state_next = S_DONE;
      S_DONE: begin
        w_state_next = S_IDLE;
        if_done      = !r_owner_mem;
        mem_done     = r_owner_mem;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_if_inst   <= '0;
      r_mem_rdata <= '0;
      r_owner_mem <= 1'b0;
      r_ram_a     <= '0;
      r_ram_dout  <= '0;
      r_ram_wr    <= 1'b0;
    end else begin
      r_buf <= w_buf_next;
      if (w_accept_mem || w_accept_if) begin
        r_base      <= w_accept_mem ? mem_addr : if_addr;
        r_ram_a     <= w_accept_mem ? mem_addr : if_addr;
        r_len       <= w_accept_mem ? w_mem_len : 3'd4;
        r_wdata     <= mem_wdata;
        r_ram_dout  <= mem_wdata[7:0];
        r_ram_wr    <= w_accept_mem && mem_we;
        r_owner_mem <= w_accept_mem;
        r_cnt       <= '0;
        r_buf       <= '0;
      end else if (w_rd) begin
        r_cnt <= w_cnt_inc;
        if (w_cnt_inc < r_len) r_ram_a <= w_addr_next;
        if (w_last_cap) begin
          if (r_owner_mem) r_mem_rdata <= w_buf_next;
          else             r_if_inst   <= w_buf_next;
        end
      end else if (r_state == S_MEM_WR) begin
        if (w_last_wr) begin
          r_ram_wr <= 1'b0;
        end else begin
          r_cnt      <= w_cnt_inc;
          r_ram_a    <= w_addr_next;
          r_ram_dout <= w_wr_byte;
        end
      end
    end
  end

  // Stall priority: MEM activity freezes up to MEM/WB, load-use bubbles ID/EX, fetch holds PC and IF/ID
  always_comb begin
    stall = 6'b000000;
    if ((r_state == S_MEM_RD) || (r_state == S_MEM_WR) || (mem_req && !mem_done))
      stall = 6'b011111;
    else if (id_stallreq)
      stall = 6'b000111;
    else if ((r_state == S_IF_RD) || (if_req && !if_done))
      stall = 6'b000011;
  end

  assign if_inst   = r_if_inst;
  assign mem_rdata = r_mem_rdata;
  assign ram_a     = r_ram_a;
  assign ram_dout  = r_ram_dout;
  assign ram_wr    = r_ram_wr;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: behavioural byte RAM, per-cycle stall/write checks,
// and a scoreboard of expected completions (data and completion cycle).
module tb_mem_ctrl;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [31:0]   if_inst;
  logic          if_done;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [1:0]    mem_len = 2'b00;
  logic [AW-1:0] mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [31:0]   mem_rdata;
  logic          mem_done;
  logic          id_stallreq = 1'b0;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_dout;
  logic          ram_wr;
  logic [7:0]    ram_din;
  logic [5:0]    stall;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .id_stallreq(id_stallreq),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
    .stall(stall)
  );

  always #5 clk = ~clk;

  // RAM with one-cycle read latency plus a backdoor load port
  logic [7:0]    ram [0:(1<<AW)-1];
  logic          tb_ld = 1'b0;
  logic [AW-1:0] tb_ld_a = '0;
  logic [7:0]    tb_ld_d = '0;
  always @(posedge clk) begin
    if (tb_ld)       ram[tb_ld_a] <= tb_ld_d;
    else if (ram_wr) ram[ram_a]   <= ram_dout;
    ram_din <= ram[ram_a];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          when;
    bit          has_data;
  } exp_t;
  exp_t if_q[$];
  exp_t mem_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int t0       = 0;
  int exp_stall [0:15];
  int exp_wr    [0:15];
  bit drop_if, drop_mem;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 16; i++) begin
      exp_stall[i] = -1;
      exp_wr[i]    = -1;
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    tb_ld = 1'b1; tb_ld_a = a; tb_ld_d = d;
    @(posedge clk); #1;
    tb_ld = 1'b0;
  endtask

  // One cycle: sample at negedge, retire completions, then move to the next drive point
  task automatic step();
    int   rel;
    exp_t e;
    @(negedge clk);
    rel = cyc - t0;
    if (rel >= 0 && rel < 16) begin
      if (exp_stall[rel] >= 0)
        chk($sformatf("stall_c%0d", rel), {26'd0, stall}, exp_stall[rel]);
      if (exp_wr[rel] >= 0)
        chk($sformatf("ram_wr_c%0d", rel), {31'd0, ram_wr}, exp_wr[rel]);
    end
    if (if_done) begin
      chk("if_done_expected", {31'd0, (if_q.size() != 0)}, 32'd1);
      if (if_q.size() != 0) begin
        e = if_q.pop_front();
        chk("if_done_cycle", rel, e.when);
        if (e.has_data) chk("if_inst", if_inst, e.data);
      end
      drop_if = 1'b1;
    end
    if (mem_done) begin
      chk("mem_done_expected", {31'd0, (mem_q.size() != 0)}, 32'd1);
      if (mem_q.size() != 0) begin
        e = mem_q.pop_front();
        chk("mem_done_cycle", rel, e.when);
        if (e.has_data) chk("mem_rdata", mem_rdata, e.data);
      end
      drop_mem = 1'b1;
    end
    @(posedge clk); #1;
    if (drop_if)  begin if_req  = 1'b0; drop_if  = 1'b0; end
    if (drop_mem) begin mem_req = 1'b0; drop_mem = 1'b0; end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
    chk("if_q_drained",  if_q.size(),  32'd0);
    chk("mem_q_drained", mem_q.size(), 32'd0);
  endtask

  initial begin
    drop_if = 1'b0; drop_mem = 1'b0;
    clear_exp();
    @(posedge clk); #1;
    poke(17'h00100, 8'h13); poke(17'h00101, 8'h05);
    poke(17'h00102, 8'h10); poke(17'h00103, 8'h00);
    poke(17'h00200, 8'hA5);
    poke(17'h1FFFF, 8'h00); poke(17'h00000, 8'h00);
    for (int i = 0; i < 4; i++) poke(AW'(17'h00300 + i), 8'h00);

    chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("rst_ram_a", {15'd0, ram_a}, 32'd0);
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_mem_done", {31'd0, mem_done}, 32'd0);
    chk("rst_stall", {26'd0, stall}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word fetch
    clear_exp();
    t0 = cyc; if_req = 1'b1; if_addr = 17'h00100;
    if_q.push_back('{32'h00100513, 6, 1'b1});
    for (int i = 0; i < 6; i++) exp_stall[i] = 6'b000011;
    exp_stall[6] = 0; exp_stall[7] = 0;
    run(9);

    // Simultaneous requests: MEM byte load wins, IF accepted after
    clear_exp();
    t0 = cyc; if_req = 1'b1; if_addr = 17'h00100;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 17'h00200;
    mem_q.push_back('{32'h000000A5, 3, 1'b1});
    if_q.push_back('{32'h00100513, 10, 1'b1});
    for (int i = 0; i < 3; i++) exp_stall[i] = 6'b011111;
    for (int i = 3; i < 10; i++) exp_stall[i] = 6'b000011;
    exp_stall[10] = 0; exp_stall[11] = 0;
    run(13);

    // Half store wrapping past the top of the address space
    clear_exp();
    t0 = cyc; mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b01;
    mem_addr = 17'h1FFFF; mem_wdata = 32'h0000BEEF;
    mem_q.push_back('{32'h0, 3, 1'b0});
    exp_wr[0] = 0; exp_wr[1] = 1; exp_wr[2] = 1; exp_wr[3] = 0;
    for (int i = 0; i < 3; i++) exp_stall[i] = 6'b011111;
    exp_stall[3] = 0;
    run(6);
    chk("wrap_byte_1ffff", {24'd0, ram[17'h1FFFF]}, 32'hEF);
    chk("wrap_byte_00000", {24'd0, ram[17'h00000]}, 32'hBE);
    mem_we = 1'b0;

    // No preemption: MEM request arrives mid-fetch
    clear_exp();
    t0 = cyc; if_req = 1'b1; if_addr = 17'h00100;
    if_q.push_back('{32'h00100513, 6, 1'b1});
    mem_q.push_back('{32'h000000A5, 10, 1'b1});
    exp_stall[0] = 6'b000011; exp_stall[1] = 6'b000011;
    for (int i = 2; i < 10; i++) exp_stall[i] = 6'b011111;
    exp_stall[10] = 0;
    step(); step();
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 17'h00200;
    run(11);

    // Load-use stall alone, then together with a MEM request
    clear_exp();
    t0 = cyc; id_stallreq = 1'b1;
    exp_stall[0] = 6'b000111;
    run(1);
    clear_exp();
    t0 = cyc; mem_req = 1'b1; mem_len = 2'b00; mem_addr = 17'h00200;
    mem_q.push_back('{32'h000000A5, 3, 1'b1});
    for (int i = 0; i < 3; i++) exp_stall[i] = 6'b011111;
    exp_stall[3] = 6'b000111;
    run(5);
    id_stallreq = 1'b0;

    // Reset in cycle 2 of a word store
    clear_exp();
    t0 = cyc; mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10;
    mem_addr = 17'h00300; mem_wdata = 32'h11223344;
    exp_wr[1] = 1;
    step(); step();
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    #1;
    chk("async_rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstwr_byte0", {24'd0, ram[17'h00300]}, 32'h44);
    chk("rstwr_byte1", {24'd0, ram[17'h00301]}, 32'h00);
    chk("rstwr_byte2", {24'd0, ram[17'h00302]}, 32'h00);
    chk("rstwr_byte3", {24'd0, ram[17'h00303]}, 32'h00);
    chk("post_rst_if_inst", if_inst, 32'd0);
    chk("post_rst_mem_rdata", mem_rdata, 32'd0);
    chk("post_rst_ram_a", {15'd0, ram_a}, 32'd0);
    chk("post_rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    chk("post_rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("post_rst_done", {30'd0, if_done, mem_done}, 32'd0);
    chk("post_rst_stall", {26'd0, stall}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
